// File: rtl/apb_mon_pkg.sv
// Shared types and constants for the APB4 protocol monitor.
//   apb_phase_e : bus phase tracked by the monitor FSM
//   ERR_*       : bit positions within err_flags, also the first_err_code values
//   lowest_err  : index of the lowest set bit of an error vector (priority encode)
package apb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_phase_e;

    localparam int NUM_ERR      = 7;
    localparam int ERR_SETUP    = 0;
    localparam int ERR_STABLE   = 1;
    localparam int ERR_SLVERR   = 2;
    localparam int ERR_RANGE    = 3;
    localparam int ERR_TIMEOUT  = 4;
    localparam int ERR_RSTRB    = 5;
    localparam int ERR_MULTISEL = 6;

    function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating event counter.
//   pclk   in   clock
//   preset in   synchronous active-high reset
//   clr    in   clear; an inc in the same cycle still counts (result 1)
//   inc    in   count one event
//   cnt    out  current count, holds at all-ones
module apb_mon_sat_cnt
    import apb_mon_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_WIDTH'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB4 protocol monitor. Follows the bus phase, checks ordering,
// ACCESS-phase stability, pslverr legality, address range, read strobes,
// select exclusivity and wait-state timeout, and keeps transfer counters.
//   pclk, preset                 clock, synchronous active-high reset
//   psel..pslverr                tapped APB signals (inputs only)
//   clr                          clear sticky flags, first-error capture, counters
//   err_flags / err_pulse        sticky error bits / any-error pulse
//   first_err_code / _vld        lowest error index of the first erroring cycle
//   wr_count / rd_count / err_count  saturating completed-transfer counters
//
// state  | meaning
// IDLE   | no transfer open; next sel sample starts one
// SETUP  | previous sample was a SETUP cycle; this sample must be ACCESS
// ACCESS | in ACCESS with pready still low; waiting for completion
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int NUM_SEL    = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [NUM_SEL-1:0]      psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic                    clr,
    output logic [NUM_ERR-1:0]      err_flags,
    output logic                    err_pulse,
    output logic [2:0]              first_err_code,
    output logic                    first_err_vld,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WCW    = $clog2(TIMEOUT + 1);

    apb_phase_e            phase, phase_nxt;
    logic                  cap_en, err_setup;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_write;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [STRB_W-1:0]     cap_strb;
    logic [NUM_SEL-1:0]    cap_sel;
    logic [WCW-1:0]        wait_cnt, wait_cnt_nxt;
    logic [NUM_ERR-1:0]    err_now;
    logic                  sel, access_smp, complete, wait_smp, stable_bad;

    assign sel = |psel;
    // The first ACCESS cycle is sampled while still in SETUP, so a zero-wait
    // transfer completes from SETUP as well as from ACCESS.
    assign access_smp = (phase != IDLE) && sel && penable;
    assign complete   = access_smp && pready;
    assign wait_smp   = access_smp && !pready;

    always_comb begin
        phase_nxt = phase;
        cap_en    = 1'b0;
        err_setup = 1'b0;
        case (phase)
            IDLE: begin
                if (sel) begin
                    cap_en    = 1'b1;
                    err_setup = penable;
                    phase_nxt = penable ? ACCESS : SETUP;
                end
            end
            SETUP: begin
                if (sel && penable) begin
                    phase_nxt = pready ? IDLE : ACCESS;
                end else begin
                    err_setup = 1'b1;
                    cap_en    = sel;
                    phase_nxt = sel ? SETUP : IDLE;
                end
            end
            ACCESS: begin
                if (sel && penable) begin
                    phase_nxt = pready ? IDLE : ACCESS;
                end else begin
                    err_setup = 1'b1;
                    phase_nxt = IDLE;
                end
            end
            default: phase_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (wait_smp) begin
            wait_cnt_nxt = (wait_cnt == WCW'(TIMEOUT)) ? wait_cnt : wait_cnt + WCW'(1);
        end
    end

    always_comb begin
        stable_bad = (paddr != cap_addr) || (pwrite != cap_write) || (psel != cap_sel);
        if (cap_write) begin
            stable_bad = stable_bad || (pwdata != cap_wdata) || (pstrb != cap_strb);
        end
        err_now               = '0;
        err_now[ERR_SETUP]    = err_setup;
        err_now[ERR_STABLE]   = access_smp && stable_bad;
        err_now[ERR_SLVERR]   = pslverr && !complete;
        err_now[ERR_RANGE]    = complete && !pslverr && (32'(cap_addr) >= 32'(MEM_DEPTH));
        // Counter saturates at TIMEOUT, so this edge is crossed once per transfer.
        err_now[ERR_TIMEOUT]  = wait_smp && (wait_cnt == WCW'(TIMEOUT - 1));
        err_now[ERR_RSTRB]    = sel && !pwrite && (pstrb != '0);
        err_now[ERR_MULTISEL] = (psel & (psel - NUM_SEL'(1))) != '0;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            phase          <= IDLE;
            wait_cnt       <= '0;
            cap_addr       <= '0;
            cap_write      <= 1'b0;
            cap_wdata      <= '0;
            cap_strb       <= '0;
            cap_sel        <= '0;
            err_flags      <= '0;
            err_pulse      <= 1'b0;
            first_err_code <= '0;
            first_err_vld  <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (cap_en) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_wdata <= pwdata;
                cap_strb  <= pstrb;
                cap_sel   <= psel;
            end
            err_flags <= (clr ? '0 : err_flags) | err_now;
            err_pulse <= |err_now;
            if ((clr || !first_err_vld) && (err_now != '0)) begin
                first_err_vld  <= 1'b1;
                first_err_code <= lowest_err(err_now);
            end else if (clr) begin
                first_err_vld  <= 1'b0;
                first_err_code <= '0;
            end
        end
    end

    apb_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
        .pclk(pclk), .preset(preset), .clr(clr), .inc(complete && cap_write), .cnt(wr_count)
    );
    apb_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
        .pclk(pclk), .preset(preset), .clr(clr), .inc(complete && !cap_write), .cnt(rd_count)
    );
    apb_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .pclk(pclk), .preset(preset), .clr(clr), .inc(complete && pslverr), .cnt(err_count)
    );

endmodule
